alu_cmd_ctrl: RTL and testbench
===============================

Name: alu_cmd_ctrl

Overview:
- Command-side initiator for the system ALU, which has 8-bit operands A/B, a 4-bit function select, an enable, a 16-bit registered result and a result-valid flag.
- Accepts a byte stream of commands from the serial receive path, loads operands and function, and drives the ALU through one operation.
- Captures the 16-bit result and returns it low byte first to the serial transmit path over a valid/ready handshake.
- Also controls the ALU clock-gate enable, so the ALU clock runs only while an operation is in flight.

Parameters:
- DATA_WIDTH, 8, byte/operand width
- RESULT_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH
- CMD_FULL, 8'hCC, opcode for the frame CMD, A, B, FUN
- CMD_REUSE, 8'hDD, opcode for the frame CMD, FUN (reuses last A and B)
- WAIT_LIMIT, 4, maximum cycles in WAIT_RES before timeout

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- RX_DATA  in  DATA_WIDTH  received byte
- RX_VALID  in  1  one-cycle strobe; RX_DATA is valid this cycle
- ALU_A  out  DATA_WIDTH  operand A to ALU
- ALU_B  out  DATA_WIDTH  operand B to ALU
- ALU_FUN  out  4  function select to ALU
- ALU_EN  out  1  one-cycle operation request to ALU
- ALU_RESULT  in  RESULT_WIDTH  ALU result
- ALU_OUT_VALID  in  1  ALU result-valid flag
- CLK_GATE_EN  out  1  ALU clock-gate enable
- TX_DATA  out  DATA_WIDTH  byte to transmitter
- TX_VALID  out  1  TX_DATA is valid
- TX_READY  in  1  transmitter accepts the byte
- BUSY  out  1  high while the block is not accepting command bytes
- ERR  out  1  one-cycle pulse on timeout

Behaviour:
- All outputs are registered. Reset value of every output is 0. Stored A and B also reset to 0.
- Reset asserted at any time, including mid-operation or mid-transmit, aborts the operation: state returns to IDLE and no partial result is sent.
- States: IDLE, GET_A, GET_B, GET_FUN, GATE_ON, REQ, WAIT_RES, TX_LO, TX_HI.
- IDLE, on RX_VALID:
  - CMD_FULL -> GET_A.
  - CMD_REUSE -> GET_FUN.
  - Any other byte is discarded; state stays IDLE.
- GET_A and GET_B: on RX_VALID, store the byte as A (resp. B) and advance to GET_B (resp. GET_FUN).
- GET_FUN: on RX_VALID, store RX_DATA[3:0] as FUN and ignore the upper nibble; go to GATE_ON.
- Inter-byte gaps are unbounded; the block waits indefinitely in the GET states.
- GATE_ON:
  - Assert CLK_GATE_EN and drive ALU_A, ALU_B and ALU_FUN from the stored values.
  - Next cycle -> REQ.
- CLK_GATE_EN stays high through REQ and WAIT_RES. It drops in the cycle the result is captured, or on timeout.
- REQ:
  - ALU_EN is high for exactly one cycle; next cycle -> WAIT_RES.
  - ALU_A, ALU_B and ALU_FUN hold stable from GATE_ON until leaving WAIT_RES.
- WAIT_RES:
  - The wait counter starts at 0 on entry and increments each cycle.
  - If ALU_OUT_VALID=1, capture ALU_RESULT and go to TX_LO. The nominal ALU responds on the first WAIT_RES cycle.
  - If the counter reaches WAIT_LIMIT with no valid: pulse ERR for one cycle, deassert CLK_GATE_EN, go to IDLE. No transmission occurs.
- TX_LO: TX_DATA = result[7:0] with TX_VALID=1. On TX_VALID and TX_READY both high -> TX_HI.
- TX_HI:
  - TX_DATA = result[15:8], TX_VALID held high.
  - On handshake -> IDLE; TX_VALID is low in the following cycle.
- TX_VALID and TX_DATA must not change while TX_VALID=1 and TX_READY=0.
- TX_READY may be high before TX_VALID rises. The transfer then completes in the first cycle TX_VALID is high.
- BUSY is 1 in GATE_ON, REQ, WAIT_RES, TX_LO and TX_HI; 0 otherwise.
- RX_VALID while BUSY=1: the byte is discarded with no state change. It is not queued.
- Stored A/B persist across operations and timeouts. CMD_REUSE after reset uses A=B=0.
- Minimum latency, from the FUN byte strobe to the first cycle TX_VALID=1: 4 cycles (GATE_ON, REQ, WAIT_RES, TX_LO).

Test Plan:
1. Full command. Send CC,0F,03,02; model the ALU with one-cycle latency returning 0x002D.
   Required: ALU_A=0x0F, ALU_B=0x03, ALU_FUN=2; ALU_EN high for exactly one cycle; CLK_GATE_EN covers that cycle. TX sends 0x2D then 0x00, and BUSY returns to 0.
2. Reuse command. After test 1, send DD,F0; ALU returns 0x0012.
   Required: A=0x0F, B=0x03, FUN=0 (upper nibble ignored). TX sends 0x12 then 0x00.
3. Backpressure. Hold TX_READY=0 for 5 cycles in TX_LO, then 1.
   Required: TX_DATA stays 0x2D with TX_VALID high throughout. Exactly two transfers occur, in order.
4. Timeout. Never assert ALU_OUT_VALID.
   Required: ERR pulses once after WAIT_LIMIT=4 WAIT_RES cycles, CLK_GATE_EN drops, no TX_VALID, state is IDLE. A following CC frame completes normally.
5. Junk and overlap.
   - 0x55 in IDLE is ignored: the next CC frame still parses correctly.
   - RX_VALID during WAIT_RES and TX is dropped: no extra ALU_EN, no extra TX bytes.
6. Reset mid-transmit. Assert RST low while in TX_HI with TX_READY=0.
   Required: all outputs 0 immediately. After release, a CC,05,05,0A frame yields ALU_FUN=0xA, and TX sends exactly result low then high.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// Command-side initiator for the system ALU: parses CC/DD command frames, runs one
// gated ALU operation and returns the 16-bit result low byte first over valid/ready.
module alu_cmd_ctrl #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    RESULT_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] CMD_FULL     = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_REUSE    = 8'hDD,
    parameter int                    WAIT_LIMIT   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_DATA,
    input  logic                    RX_VALID,
    output logic [DATA_WIDTH-1:0]   ALU_A,
    output logic [DATA_WIDTH-1:0]   ALU_B,
    output logic [3:0]              ALU_FUN,
    output logic                    ALU_EN,
    input  logic [RESULT_WIDTH-1:0] ALU_RESULT,
    input  logic                    ALU_OUT_VALID,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VALID,
    input  logic                    TX_READY,
    output logic                    BUSY,
    output logic                    ERR
);

    // state    | meaning
    // IDLE     | waiting for an opcode byte; other bytes dropped
    // GET_A    | next byte is operand A
    // GET_B    | next byte is operand B
    // GET_FUN  | next byte carries the function select in its low nibble
    // GATE_ON  | ALU clock enabled, operands presented
    // REQ      | one-cycle ALU_EN
    // WAIT_RES | waiting for ALU_OUT_VALID, bounded by WAIT_LIMIT cycles
    // TX_LO    | offering result low byte
    // TX_HI    | offering result high byte
    typedef enum logic [3:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_FUN,
        GATE_ON,
        REQ,
        WAIT_RES,
        TX_LO,
        TX_HI
    } state_t;

    localparam int                CNT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_nxt;
    logic [DATA_WIDTH-1:0]   reg_a, reg_a_nxt;
    logic [DATA_WIDTH-1:0]   reg_b, reg_b_nxt;
    logic [3:0]              reg_fun, reg_fun_nxt;
    logic [RESULT_WIDTH-1:0] result, result_nxt;

    logic [DATA_WIDTH-1:0]   alu_a_nxt;
    logic [DATA_WIDTH-1:0]   alu_b_nxt;
    logic [3:0]              alu_fun_nxt;
    logic                    alu_en_nxt;
    logic                    gate_nxt;
    logic [DATA_WIDTH-1:0]   tx_data_nxt;
    logic                    tx_valid_nxt;
    logic                    busy_nxt;
    logic                    err_nxt;
    logic                    tx_fire;

    assign tx_fire = TX_VALID && TX_READY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            reg_a       <= '0;
            reg_b       <= '0;
            reg_fun     <= '0;
            result      <= '0;
            ALU_A       <= '0;
            ALU_B       <= '0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            TX_DATA     <= '0;
            TX_VALID    <= 1'b0;
            BUSY        <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            reg_a       <= reg_a_nxt;
            reg_b       <= reg_b_nxt;
            reg_fun     <= reg_fun_nxt;
            result      <= result_nxt;
            ALU_A       <= alu_a_nxt;
            ALU_B       <= alu_b_nxt;
            ALU_FUN     <= alu_fun_nxt;
            ALU_EN      <= alu_en_nxt;
            CLK_GATE_EN <= gate_nxt;
            TX_DATA     <= tx_data_nxt;
            TX_VALID    <= tx_valid_nxt;
            BUSY        <= busy_nxt;
            ERR         <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        reg_a_nxt    = reg_a;
        reg_b_nxt    = reg_b;
        reg_fun_nxt  = reg_fun;
        result_nxt   = result;
        err_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (RX_VALID) begin
                    if (RX_DATA == CMD_FULL) begin
                        state_nxt = GET_A;
                    end else if (RX_DATA == CMD_REUSE) begin
                        state_nxt = GET_FUN;
                    end
                end
            end
            GET_A: begin
                if (RX_VALID) begin
                    reg_a_nxt = RX_DATA;
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (RX_VALID) begin
                    reg_b_nxt = RX_DATA;
                    state_nxt = GET_FUN;
                end
            end
            GET_FUN: begin
                if (RX_VALID) begin
                    reg_fun_nxt = RX_DATA[3:0];
                    state_nxt   = GATE_ON;
                end
            end
            GATE_ON: begin
                state_nxt = REQ;
            end
            REQ: begin
                wait_cnt_nxt = '0;
                state_nxt    = WAIT_RES;
            end
            WAIT_RES: begin
                if (ALU_OUT_VALID) begin
                    result_nxt = ALU_RESULT;
                    state_nxt  = TX_LO;
                end else if (wait_cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            TX_LO: begin
                if (tx_fire) begin
                    state_nxt = TX_HI;
                end
            end
            TX_HI: begin
                if (tx_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered yet aligned to it.
        gate_nxt     = (state_nxt == GATE_ON) || (state_nxt == REQ) || (state_nxt == WAIT_RES);
        alu_en_nxt   = (state_nxt == REQ);
        tx_valid_nxt = (state_nxt == TX_LO) || (state_nxt == TX_HI);
        busy_nxt     = gate_nxt || tx_valid_nxt;

        alu_a_nxt   = '0;
        alu_b_nxt   = '0;
        alu_fun_nxt = '0;
        if (gate_nxt) begin
            alu_a_nxt   = reg_a_nxt;
            alu_b_nxt   = reg_b_nxt;
            alu_fun_nxt = reg_fun_nxt;
        end

        tx_data_nxt = '0;
        if (state_nxt == TX_LO) begin
            tx_data_nxt = result_nxt[DATA_WIDTH-1:0];
        end else if (state_nxt == TX_HI) begin
            tx_data_nxt = result_nxt[RESULT_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl: expected ALU requests and TX bytes are queued
// by the stimulus and checked by an independent monitor.
module tb_alu_cmd_ctrl;

    logic        CLK;
    logic        RST;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_RESULT;
    logic        ALU_OUT_VALID;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        BUSY;
    logic        ERR;

    int          vectors     = 0;
    int          miscompares = 0;
    int          err_pulses  = 0;
    logic [7:0]  tx_q[$];
    logic [19:0] op_q[$];
    logic [15:0] alu_result_val;
    bit          alu_respond;

    alu_cmd_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_DATA       (RX_DATA),
        .RX_VALID      (RX_VALID),
        .ALU_A         (ALU_A),
        .ALU_B         (ALU_B),
        .ALU_FUN       (ALU_FUN),
        .ALU_EN        (ALU_EN),
        .ALU_RESULT    (ALU_RESULT),
        .ALU_OUT_VALID (ALU_OUT_VALID),
        .CLK_GATE_EN   (CLK_GATE_EN),
        .TX_DATA       (TX_DATA),
        .TX_VALID      (TX_VALID),
        .TX_READY      (TX_READY),
        .BUSY          (BUSY),
        .ERR           (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ALU model: one-cycle latency after the ALU_EN cycle
    initial begin
        ALU_OUT_VALID = 1'b0;
        ALU_RESULT    = 16'h0000;
        forever begin
            @(negedge CLK);
            if (RST && ALU_EN && alu_respond) begin
                @(posedge CLK);
                #1;
                ALU_OUT_VALID = 1'b1;
                ALU_RESULT    = alu_result_val;
                @(posedge CLK);
                #1;
                ALU_OUT_VALID = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic       hold;
        logic [7:0] held;
        logic [19:0] exp_op;
        logic [7:0]  exp_tx;
        hold = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check("tx_hold_valid", 64'(TX_VALID), 64'h1);
                check("tx_hold_data", 64'(TX_DATA), 64'(held));
            end
            if (ALU_EN) begin
                check("gate_during_en", 64'(CLK_GATE_EN), 64'h1);
                if (op_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL alu_en_extra: got request A=0x%0h B=0x%0h FUN=0x%0h, expected none",
                             ALU_A, ALU_B, ALU_FUN);
                end else begin
                    exp_op = op_q.pop_front();
                    check("alu_op", 64'({ALU_A, ALU_B, ALU_FUN}), 64'(exp_op));
                end
            end
            if (TX_VALID && TX_READY) begin
                if (tx_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_extra: got byte 0x%0h, expected none", TX_DATA);
                end else begin
                    exp_tx = tx_q.pop_front();
                    check("tx_byte", 64'(TX_DATA), 64'(exp_tx));
                end
            end
            if (ERR) err_pulses++;
            hold = TX_VALID && !TX_READY;
            held = TX_DATA;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(posedge CLK);
        #1;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
    endtask

    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        op_q.push_back({a, b, f});
    endtask

    task automatic push_result(input logic [15:0] r);
        tx_q.push_back(r[7:0]);
        tx_q.push_back(r[15:8]);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((BUSY || tx_q.size() != 0 || op_q.size() != 0) && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(name, 64'({op_q.size() != 0, tx_q.size() != 0, BUSY}), 64'h0);
    endtask

    task automatic wait_tx_valid(input string name);
        int n;
        n = 0;
        while (!TX_VALID && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(name, 64'(TX_VALID), 64'h1);
    endtask

    initial begin : stim
        int c;
        int err_before;
        RST         = 1'b0;
        RX_DATA     = 8'h00;
        RX_VALID    = 1'b0;
        TX_READY    = 1'b1;
        alu_respond = 1'b1;
        alu_result_val = 16'h0000;
        #1;
        check("reset_outputs",
              64'({ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_DATA, TX_VALID, BUSY, ERR}), 64'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;

        // 1: full command, 15*3
        alu_result_val = 16'h002D;
        push_op(8'h0F, 8'h03, 4'h2);
        push_result(16'h002D);
        send_byte(8'hCC);
        send_byte(8'h0F);
        send_byte(8'h03);
        send_byte(8'h02);
        c = 0;
        while (!TX_VALID && c < 20) begin
            @(posedge CLK);
            #1;
            c++;
        end
        check("latency_edges", 64'(c), 64'd3);
        wait_done("t1_done");

        // 2: reuse A/B, upper nibble of FUN byte ignored, 15+3
        alu_result_val = 16'h0012;
        push_op(8'h0F, 8'h03, 4'h0);
        push_result(16'h0012);
        send_byte(8'hDD);
        send_byte(8'hF0);
        wait_done("t2_done");

        // 3: backpressure in TX_LO
        TX_READY = 1'b0;
        alu_result_val = 16'h002D;
        push_op(8'h0F, 8'h03, 4'h2);
        push_result(16'h002D);
        send_byte(8'hCC);
        send_byte(8'h0F);
        send_byte(8'h03);
        send_byte(8'h02);
        wait_tx_valid("t3_valid_seen");
        for (int i = 0; i < 5; i++) begin
            check("bp_data", 64'(TX_DATA), 64'h2D);
            check("bp_valid", 64'(TX_VALID), 64'h1);
            @(posedge CLK);
            #1;
        end
        TX_READY = 1'b1;
        wait_done("t3_done");

        // 4: timeout, then a normal frame (7-2)
        alu_respond = 1'b0;
        err_before  = err_pulses;
        push_op(8'h0F, 8'h03, 4'h7);
        send_byte(8'hDD);
        send_byte(8'h07);
        c = 0;
        while (!ERR && c < 20) begin
            @(posedge CLK);
            #1;
            c++;
        end
        check("timeout_edges", 64'(c), 64'd6);
        check("timeout_err", 64'(ERR), 64'h1);
        check("timeout_gate", 64'(CLK_GATE_EN), 64'h0);
        check("timeout_state", 64'({TX_VALID, BUSY}), 64'h0);
        @(posedge CLK);
        #1;
        check("err_one_cycle", 64'(ERR), 64'h0);
        alu_respond = 1'b1;
        @(posedge CLK);
        #1;
        check("err_pulse_count", 64'(err_pulses - err_before), 64'd1);
        alu_result_val = 16'h0005;
        push_op(8'h07, 8'h02, 4'h1);
        push_result(16'h0005);
        send_byte(8'hCC);
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h01);
        wait_done("t4_done");

        // 5: junk in IDLE, then bytes dropped while busy (0x10+0x20)
        send_byte(8'h55);
        alu_result_val = 16'h0030;
        push_op(8'h10, 8'h20, 4'h0);
        push_result(16'h0030);
        TX_READY = 1'b0;
        send_byte(8'hCC);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'hCC);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'hDD);
        send_byte(8'h00);
        check("t5_busy_hold", 64'({TX_VALID, BUSY}), 64'h3);
        TX_READY = 1'b1;
        wait_done("t5_done");

        // 6: reset while holding the high byte
        TX_READY = 1'b0;
        alu_result_val = 16'h1234;
        push_op(8'hAA, 8'hBB, 4'h3);
        tx_q.push_back(8'h34);
        send_byte(8'hCC);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'h03);
        wait_tx_valid("t6_valid_seen");
        @(posedge CLK);
        #1;
        TX_READY = 1'b1;
        @(posedge CLK);
        #1;
        TX_READY = 1'b0;
        check("t6_hi_byte", 64'({TX_VALID, TX_DATA}), 64'h112);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("t6_reset_outputs",
              64'({ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_DATA, TX_VALID, BUSY, ERR}), 64'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST      = 1'b1;
        TX_READY = 1'b1;
        check("t6_partial_flushed", 64'(tx_q.size()), 64'd0);

        // stored operands cleared by reset
        alu_result_val = 16'h0000;
        push_op(8'h00, 8'h00, 4'h3);
        push_result(16'h0000);
        send_byte(8'hDD);
        send_byte(8'h03);
        wait_done("t6_reuse_done");

        alu_result_val = 16'h0019;
        push_op(8'h05, 8'h05, 4'hA);
        push_result(16'h0019);
        send_byte(8'hCC);
        send_byte(8'h05);
        send_byte(8'h05);
        send_byte(8'h0A);
        wait_done("t6_done");

        repeat (5) @(posedge CLK);
        #1;
        check("final_queues", 64'({op_q.size() != 0, tx_q.size() != 0}), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

endmodule
